// File: rtl/microwave_pkg.sv
// Shared types for the microwave cook-cycle controller: state codes, BCD digit
// and cook-time types, and the zero-time constant.
package microwave_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] bcd_t;

  localparam bcd_t BCD_MAX     = 4'd9;
  localparam bcd_t SEC_TENS_MAX = 4'd5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_COOKING = 3'd2,
    ST_PAUSED  = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  typedef struct packed {
    bcd_t min_tens;
    bcd_t min_ones;
    bcd_t sec_tens;
    bcd_t sec_ones;
  } cook_time_t;

  localparam cook_time_t ZERO_TIME = '0;
  localparam cook_time_t ONE_SEC   = '{4'd0, 4'd0, 4'd0, 4'd1};

  function automatic logic is_bcd_digit(input bcd_t d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// Four-digit BCD mm:ss store with keypad shift-in and one-second decrement.
// Priority: clear > shift > decrement.
module bcd_time_counter
  import microwave_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clear,
  input  logic       i_shift,
  input  bcd_t       i_digit,
  input  logic       i_dec,
  output cook_time_t o_time,
  output logic       o_is_zero,
  output logic       o_is_one
);

  cook_time_t r_time;
  cook_time_t w_dec_time;

  // Seconds borrow from 00 to 59; typed seconds above 59 just count down as entered.
  always_comb begin
    w_dec_time = r_time;
    if (r_time.sec_ones != '0) begin
      w_dec_time.sec_ones = r_time.sec_ones - bcd_t'(1);
    end else begin
      w_dec_time.sec_ones = BCD_MAX;
      if (r_time.sec_tens != '0) begin
        w_dec_time.sec_tens = r_time.sec_tens - bcd_t'(1);
      end else begin
        w_dec_time.sec_tens = SEC_TENS_MAX;
        if (r_time.min_ones != '0) begin
          w_dec_time.min_ones = r_time.min_ones - bcd_t'(1);
        end else begin
          w_dec_time.min_ones = BCD_MAX;
          w_dec_time.min_tens = r_time.min_tens - bcd_t'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_time <= ZERO_TIME;
    end else if (i_clear) begin
      r_time <= ZERO_TIME;
    end else if (i_shift) begin
      r_time <= '{r_time.min_ones, r_time.sec_tens, r_time.sec_ones, i_digit};
    end else if (i_dec) begin
      r_time <= w_dec_time;
    end
  end

  assign o_time    = r_time;
  assign o_is_zero = (r_time == ZERO_TIME);
  assign o_is_one  = (r_time == ONE_SEC);

endmodule

// File: rtl/cook_sequencer.sv
// Microwave cook-cycle controller: synchronises the panel buttons and door switch,
// sequences IDLE/ENTRY/COOKING/PAUSED/DONE and counts the cook time down once a second.
module cook_sequencer
  import microwave_pkg::*;
#(
  parameter int TICK_DIV   = 50_000_000,
  parameter int BEEP_TICKS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       startn,
  input  logic       stopn,
  input  logic       clearn,
  input  logic       door_closed,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  output logic       magnetron_on,
  output logic       done_beep,
  output logic [2:0] state,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BEEP_TICKS - 1);

  // Bit order {door_closed, clearn, stopn, startn}; all idle high.
  logic [3:0] w_async_in;
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic       r_start_d;
  logic       r_stop_d;

  logic w_start_ev;
  logic w_stop_ev;
  logic w_clear;
  logic w_door_open;
  logic w_key_ok;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PW-1:0]   r_presc;
  logic [PW-1:0]   w_presc_nxt;
  logic [BW-1:0]   r_beep;
  logic [BW-1:0]   w_beep_nxt;
  logic            w_tick;

  logic       w_tc_clear;
  logic       w_tc_shift;
  logic       w_tc_dec;
  cook_time_t w_time;
  logic       w_is_zero;
  logic       w_is_one;

  assign w_async_in = {door_closed, clearn, stopn, startn};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= '1;
      r_sync2   <= '1;
      r_start_d <= 1'b1;
      r_stop_d  <= 1'b1;
    end else begin
      r_sync1   <= w_async_in;
      r_sync2   <= r_sync1;
      r_start_d <= r_sync2[0];
      r_stop_d  <= r_sync2[1];
    end
  end

  // Start/stop fire once per press on the synchronised falling edge; clear/door are levels.
  assign w_start_ev  = r_start_d & ~r_sync2[0];
  assign w_stop_ev   = r_stop_d  & ~r_sync2[1];
  assign w_clear     = ~r_sync2[2];
  assign w_door_open = ~r_sync2[3];
  assign w_key_ok    = key_valid & is_bcd_digit(key_digit);
  assign w_tick      = (r_presc == P_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_presc <= '0;
      r_beep  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_presc <= w_presc_nxt;
      r_beep  <= w_beep_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_beep_nxt  = r_beep;
    w_tc_clear  = 1'b0;
    w_tc_shift  = 1'b0;
    w_tc_dec    = 1'b0;
    if (w_clear) begin
      w_state_nxt = ST_IDLE;
      w_tc_clear  = 1'b1;
      w_presc_nxt = '0;
      w_beep_nxt  = '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_ENTRY: begin
          // The nonzero test sees the pre-shift time, so a same-cycle key cannot enable start.
          if (w_stop_ev && (r_state == ST_ENTRY)) begin
            w_state_nxt = ST_IDLE;
            w_tc_clear  = 1'b1;
          end else if (w_start_ev && !w_door_open && !w_is_zero) begin
            w_state_nxt = ST_COOKING;
            w_presc_nxt = '0;
          end else if (w_key_ok) begin
            w_state_nxt = ST_ENTRY;
            w_tc_shift  = 1'b1;
          end
        end
        ST_COOKING: begin
          if (w_door_open || w_stop_ev) begin
            w_state_nxt = ST_PAUSED;
          end else if (w_tick) begin
            w_presc_nxt = '0;
            w_tc_dec    = 1'b1;
            if (w_is_one) begin
              w_state_nxt = ST_DONE;
              w_beep_nxt  = '0;
            end
          end else begin
            w_presc_nxt = r_presc + PW'(1);
          end
        end
        ST_PAUSED: begin
          if (w_stop_ev) begin
            w_state_nxt = ST_IDLE;
            w_tc_clear  = 1'b1;
            w_presc_nxt = '0;
          end else if (w_start_ev && !w_door_open) begin
            w_state_nxt = ST_COOKING;
          end
        end
        ST_DONE: begin
          if (w_stop_ev || w_start_ev) begin
            w_state_nxt = ST_IDLE;
            w_presc_nxt = '0;
            w_beep_nxt  = '0;
          end else if (w_tick) begin
            w_presc_nxt = '0;
            if (r_beep == B_LAST) begin
              w_state_nxt = ST_IDLE;
              w_beep_nxt  = '0;
            end else begin
              w_beep_nxt = r_beep + BW'(1);
            end
          end else begin
            w_presc_nxt = r_presc + PW'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_tc_clear  = 1'b1;
          w_presc_nxt = '0;
          w_beep_nxt  = '0;
        end
      endcase
    end
  end

  bcd_time_counter u_time (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_tc_clear),
    .i_shift   (w_tc_shift),
    .i_digit   (key_digit),
    .i_dec     (w_tc_dec),
    .o_time    (w_time),
    .o_is_zero (w_is_zero),
    .o_is_one  (w_is_one)
  );

  assign state        = r_state;
  assign magnetron_on = (r_state == ST_COOKING);
  assign done_beep    = (r_state == ST_DONE);
  assign min_tens     = w_time.min_tens;
  assign min_ones     = w_time.min_ones;
  assign sec_tens     = w_time.sec_tens;
  assign sec_ones     = w_time.sec_ones;

endmodule

// File: tb/tb_cook_sequencer.sv
// Bench for cook_sequencer: a seconds/minutes model checked every cycle plus
// directed scenarios with literal expectations.
module tb_cook_sequencer;

  localparam int TD = 4;
  localparam int BT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       startn = 1'b1, stopn = 1'b1, clearn = 1'b1, door_closed = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       magnetron_on, done_beep;
  logic [2:0] state;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  cook_sequencer #(.TICK_DIV(TD), .BEEP_TICKS(BT)) dut (
    .clk(clk), .rst(rst), .startn(startn), .stopn(stopn), .clearn(clearn),
    .door_closed(door_closed), .key_valid(key_valid), .key_digit(key_digit),
    .magnetron_on(magnetron_on), .done_beep(done_beep), .state(state),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: minutes and seconds as integers, a cycle count for the 1 s tick.
  // Button histories: [0]=value before the previous edge, [1]=two edges back, [2]=three back.
  int m_state, m_min, m_sec, m_cnt, m_beep;
  logic [2:0] h_st, h_sp, h_cl, h_dr;
  bit e_clr, e_open, e_stop, e_start, e_key, e_zero;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = 0; m_min = 0; m_sec = 0; m_cnt = 0; m_beep = 0;
      h_st = 3'b111; h_sp = 3'b111; h_cl = 3'b111; h_dr = 3'b111;
    end else begin
      e_clr   = !h_cl[1];
      e_open  = !h_dr[1];
      e_stop  = h_sp[2] && !h_sp[1];
      e_start = h_st[2] && !h_st[1];
      e_key   = key_valid && (key_digit < 10);
      e_zero  = (m_min == 0) && (m_sec == 0);
      if (e_clr) begin
        m_state = 0; m_min = 0; m_sec = 0; m_cnt = 0; m_beep = 0;
      end else if (m_state == 4) begin
        if (e_stop || e_start) begin
          m_state = 0; m_cnt = 0; m_beep = 0;
        end else begin
          m_cnt++;
          if (m_cnt == TD) begin
            m_cnt = 0;
            m_beep++;
            if (m_beep == BT) begin m_state = 0; m_beep = 0; end
          end
        end
      end else if (m_state == 2) begin
        if (e_open || e_stop) m_state = 3;
        else begin
          m_cnt++;
          if (m_cnt == TD) begin
            m_cnt = 0;
            if (m_sec > 0) m_sec--;
            else begin m_sec = 59; m_min--; end
            if (m_min == 0 && m_sec == 0) begin m_state = 4; m_beep = 0; end
          end
        end
      end else if (e_stop && (m_state == 3 || m_state == 1)) begin
        m_state = 0; m_min = 0; m_sec = 0; m_cnt = 0;
      end else if (e_start && !e_open && (m_state == 3 || !e_zero)) begin
        if (m_state != 3) m_cnt = 0;
        m_state = 2;
      end else if (e_key && (m_state == 0 || m_state == 1)) begin
        m_min   = (m_min % 10) * 10 + m_sec / 10;
        m_sec   = (m_sec % 10) * 10 + int'(key_digit);
        m_state = 1;
      end
      h_st = {h_st[1:0], startn};
      h_sp = {h_sp[1:0], stopn};
      h_cl = {h_cl[1:0], clearn};
      h_dr = {h_dr[1:0], door_closed};
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("state", int'(state), m_state);
      check("magnetron_on", int'(magnetron_on), int'(m_state == 2));
      check("done_beep", int'(done_beep), int'(m_state == 4));
      check("min_tens", int'(min_tens), m_min / 10);
      check("min_ones", int'(min_ones), m_min % 10);
      check("sec_tens", int'(sec_tens), m_sec / 10);
      check("sec_ones", int'(sec_ones), m_sec % 10);
    end
  end

  task automatic press_key(input logic [3:0] d);
    @(negedge clk); key_valid = 1'b1; key_digit = d;
    @(negedge clk); key_valid = 1'b0; key_digit = 4'd0;
  endtask

  // Press a button for one cycle; returns #1 after the third edge, when its action lands.
  task automatic pulse(input int which);
    @(negedge clk);
    case (which)
      0: startn = 1'b0;
      1: stopn  = 1'b0;
      default: clearn = 1'b0;
    endcase
    @(posedge clk);
    @(negedge clk); startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
  endtask

  task automatic check_time(input string name, input int mt, input int mo, input int st, input int so);
    check({name, ".mt"}, int'(min_tens), mt);
    check({name, ".mo"}, int'(min_ones), mo);
    check({name, ".st"}, int'(sec_tens), st);
    check({name, ".so"}, int'(sec_ones), so);
  endtask

  int beep_cnt;

  initial begin
    #12;
    check("rst_state", int'(state), 0);
    check("rst_mag", int'(magnetron_on), 0);
    check("rst_beep", int'(done_beep), 0);
    check_time("rst_time", 0, 0, 0, 0);
    @(negedge clk); rst = 1'b0; chk_en = 1'b1;

    // 01:30 entry, start, first tick
    press_key(4'd1); press_key(4'd3); press_key(4'd0);
    check("entry_state", int'(state), 1);
    check_time("entry_0130", 0, 1, 3, 0);
    pulse(0);
    check("start_mag", int'(magnetron_on), 1);
    repeat (4) @(posedge clk); #1;
    check_time("tick_0129", 0, 1, 2, 9);
    pulse(2);
    check("clear_state", int'(state), 0);
    check_time("clear_time", 0, 0, 0, 0);

    // minute borrow
    press_key(4'd1); press_key(4'd0); press_key(4'd0);
    pulse(0);
    repeat (4) @(posedge clk); #1;
    check_time("borrow_0059", 0, 0, 5, 9);
    pulse(2);

    // 00:02 runs to DONE, beep for BEEP_TICKS seconds, back to IDLE
    press_key(4'd2);
    pulse(0);
    repeat (8) @(posedge clk); #1;
    check("done_state", int'(state), 4);
    check("done_beep", int'(done_beep), 1);
    check_time("done_time", 0, 0, 0, 0);
    beep_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done_beep) beep_cnt++;
    end
    check("beep_len", beep_cnt, 12);
    check("after_done", int'(state), 0);

    // door opened mid-cook pauses; resume keeps prescaler
    press_key(4'd4); press_key(4'd5);
    pulse(0);
    @(negedge clk); door_closed = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("door_state", int'(state), 3);
    check("door_mag", int'(magnetron_on), 0);
    check_time("door_0045", 0, 0, 4, 5);
    repeat (6) @(posedge clk); #1;
    check_time("frozen_0045", 0, 0, 4, 5);
    @(negedge clk); door_closed = 1'b1;
    repeat (4) @(posedge clk);
    pulse(0);
    check("resume_state", int'(state), 2);
    repeat (2) @(posedge clk); #1;
    check_time("resume_0044", 0, 0, 4, 4);

    // stop pauses, second stop clears
    pulse(1);
    check("stop1_state", int'(state), 3);
    repeat (3) @(posedge clk);
    pulse(1);
    check("stop2_state", int'(state), 0);
    check_time("stop2_time", 0, 0, 0, 0);

    // start at 00:00, invalid key, clear+start together
    pulse(0);
    repeat (3) @(posedge clk); #1;
    check("start_zero", int'(state), 0);
    press_key(4'hA);
    check("badkey_state", int'(state), 0);
    check_time("badkey_time", 0, 0, 0, 0);
    press_key(4'd5);
    check_time("key5", 0, 0, 0, 5);
    @(negedge clk); clearn = 1'b0; startn = 1'b0;
    @(negedge clk); clearn = 1'b1; startn = 1'b1;
    repeat (4) @(posedge clk); #1;
    check("clr_start", int'(state), 0);
    check_time("clr_start_time", 0, 0, 0, 0);

    // async reset between edges
    press_key(4'd3);
    pulse(0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_state", int'(state), 0);
    check("arst_mag", int'(magnetron_on), 0);
    check("arst_beep", int'(done_beep), 0);
    check_time("arst_time", 0, 0, 0, 0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
